// File: rtl/raz_multi_chn_gen.sv
// ----------------------------------------------------------------------------
// raz_multi_chn_gen : multi-channel external RAZ pulse generator   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module raz_multi_chn_gen #(
  parameter int N_CHN       = 4,
  parameter int DLY_W       = 6,
  parameter int WID_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [N_CHN-1:0] TriggerIn,
  input  logic [N_CHN-1:0] RazEn,
  input  logic             GlobalMode,
  input  logic [DLY_W-1:0] DelayTime,
  input  logic [WID_W-1:0] PulseWidth,
  input  logic [WID_W-1:0] HoldOff,
  input  logic             ForceRaz,
  input  logic             ClearMissed,
  output logic [N_CHN-1:0] RAZ_CHN,
  output logic [N_CHN-1:0] Busy,
  output logic [15:0]      MissedCnt
);

  localparam int c_CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][N_CHN-1:0] r_sync;
  logic [N_CHN-1:0]                  r_prev;
  logic [15:0]                       r_missed;
  logic [N_CHN-1:0]                  w_rise;
  logic [N_CHN-1:0]                  w_req;
  logic [N_CHN-1:0]                  w_start;
  logic [N_CHN-1:0]                  w_idle;
  logic                              w_miss;
  logic [WID_W-1:0]                  w_width_eff;
  logic [c_CNT_W-1:0]                w_dly_m1;
  logic [c_CNT_W-1:0]                w_wid_m1;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], TriggerIn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_req   = w_rise & RazEn;
  // In global mode one accepted rise fans out to every enabled channel
  assign w_start = GlobalMode ? ({N_CHN{|w_req}} & RazEn) : w_req;
  assign w_miss  = |(w_start & ~w_idle);

  assign w_width_eff = (PulseWidth == '0) ? {{(WID_W-1){1'b0}}, 1'b1} : PulseWidth;
  assign w_dly_m1    = c_CNT_W'(DelayTime) - c_CNT_W'(1);
  assign w_wid_m1    = c_CNT_W'(w_width_eff) - c_CNT_W'(1);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_missed <= '0;
    end else if (ClearMissed) begin
      r_missed <= '0;
    end else if (w_miss && (r_missed != 16'hFFFF)) begin
      r_missed <= r_missed + 16'd1;
    end
  end

  assign MissedCnt = r_missed;

  generate
    for (genvar g = 0; g < N_CHN; g++) begin : g_chn
      state_t             r_state;
      logic [c_CNT_W-1:0] r_cnt;
      logic [WID_W-1:0]   r_wid;
      logic [WID_W-1:0]   r_hold;
      logic               r_raz;
      logic               r_busy;

      // Outputs are computed from the next state so they align with it
      always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_wid   <= '0;
          r_hold  <= '0;
          r_raz   <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_raz <= ForceRaz;
          case (r_state)
            S_IDLE: begin
              if (w_start[g]) begin
                r_wid  <= w_width_eff;
                r_hold <= HoldOff;
                r_busy <= 1'b1;
                if (DelayTime == '0) begin
                  r_state <= S_PULSE;
                  r_cnt   <= w_wid_m1;
                  r_raz   <= 1'b1;
                end else begin
                  r_state <= S_DELAY;
                  r_cnt   <= w_dly_m1;
                end
              end
            end
            S_DELAY: begin
              if (r_cnt == '0) begin
                r_state <= S_PULSE;
                r_cnt   <= c_CNT_W'(r_wid) - c_CNT_W'(1);
                r_raz   <= 1'b1;
              end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
              end
            end
            S_PULSE: begin
              if (r_cnt == '0) begin
                if (r_hold != '0) begin
                  r_state <= S_HOLD;
                  r_cnt   <= c_CNT_W'(r_hold) - c_CNT_W'(1);
                end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
                r_raz <= 1'b1;
              end
            end
            S_HOLD: begin
              if (r_cnt == '0) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end

      assign w_idle[g]  = (r_state == S_IDLE);
      assign RAZ_CHN[g] = r_raz;
      assign Busy[g]    = r_busy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_raz_multi_chn_gen.sv
// ----------------------------------------------------------------------------
// tb_raz_multi_chn_gen : directed testbench for raz_multi_chn_gen   rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_raz_multi_chn_gen;

  logic        Clk;
  logic        reset_n;
  logic [3:0]  TriggerIn;
  logic [3:0]  RazEn;
  logic        GlobalMode;
  logic [5:0]  DelayTime;
  logic [7:0]  PulseWidth;
  logic [7:0]  HoldOff;
  logic        ForceRaz;
  logic        ClearMissed;
  logic [3:0]  RAZ_CHN;
  logic [3:0]  Busy;
  logic [15:0] MissedCnt;

  int total = 0;
  int bad   = 0;

  raz_multi_chn_gen #(
    .N_CHN(4), .DLY_W(6), .WID_W(8), .SYNC_STAGES(2)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .TriggerIn(TriggerIn), .RazEn(RazEn),
    .GlobalMode(GlobalMode), .DelayTime(DelayTime), .PulseWidth(PulseWidth),
    .HoldOff(HoldOff), .ForceRaz(ForceRaz), .ClearMissed(ClearMissed),
    .RAZ_CHN(RAZ_CHN), .Busy(Busy), .MissedCnt(MissedCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Loop index j below means: inputs set before the j-th negedge wait are
  // sampled at edge k+j, and outputs checked after it reflect edge k+j.
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (RAZ_CHN !== 4'h0) begin bad++; $display("FAIL reset_raz got=%h exp=0", RAZ_CHN); end
    total++; if (Busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", Busy); end
    total++; if (MissedCnt !== 16'h0) begin bad++; $display("FAIL reset_missed got=%h exp=0", MissedCnt); end
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [3:0] er, eb;
    DelayTime = 6'd3; PulseWidth = 8'd10; HoldOff = 8'd0;
    for (int j = 0; j < 20; j++) begin
      TriggerIn = (j < 3) ? 4'b0001 : 4'b0000;
      @(negedge Clk);
      er = (j >= 5 && j <= 14) ? 4'b0001 : 4'b0000;
      eb = (j >= 2 && j <= 14) ? 4'b0001 : 4'b0000;
      total++; if (RAZ_CHN !== er) begin bad++; $display("FAIL basic_raz j=%0d got=%b exp=%b", j, RAZ_CHN, er); end
      total++; if (Busy !== eb) begin bad++; $display("FAIL basic_busy j=%0d got=%b exp=%b", j, Busy, eb); end
    end
  endtask

  task automatic test_zero_delay_width();
    logic [3:0] er;
    DelayTime = 6'd0; PulseWidth = 8'd0; HoldOff = 8'd0;
    for (int j = 0; j < 6; j++) begin
      TriggerIn = (j < 2) ? 4'b0001 : 4'b0000;
      @(negedge Clk);
      er = (j == 2) ? 4'b0001 : 4'b0000;
      total++; if (RAZ_CHN !== er) begin bad++; $display("FAIL zero_raz j=%0d got=%b exp=%b", j, RAZ_CHN, er); end
    end
  endtask

  task automatic test_global();
    logic [3:0] er;
    GlobalMode = 1'b1; RazEn = 4'b1011;
    DelayTime = 6'd1; PulseWidth = 8'd2; HoldOff = 8'd0;
    for (int j = 0; j < 8; j++) begin
      TriggerIn = (j < 2) ? 4'b0010 : 4'b0000;
      @(negedge Clk);
      er = (j == 3 || j == 4) ? 4'b1011 : 4'b0000;
      total++; if (RAZ_CHN !== er) begin bad++; $display("FAIL global_raz j=%0d got=%b exp=%b", j, RAZ_CHN, er); end
    end
    GlobalMode = 1'b0; RazEn = 4'b1111;
  endtask

  task automatic test_missed();
    int pulses = 0;
    ClearMissed = 1'b1; @(negedge Clk); ClearMissed = 1'b0;
    DelayTime = 6'd0; PulseWidth = 8'd10; HoldOff = 8'd20;
    for (int j = 0; j < 41; j++) begin
      TriggerIn = ((j < 2) || (j >= 15 && j < 17)) ? 4'b0001 : 4'b0000;
      @(negedge Clk);
      if (RAZ_CHN[0]) pulses++;
      if (j == 31) begin
        total++; if (Busy[0] !== 1'b1) begin bad++; $display("FAIL missed_busy_hold got=%b exp=1", Busy[0]); end
      end
    end
    total++; if (pulses != 10) begin bad++; $display("FAIL missed_pulse_cnt got=%0d exp=10", pulses); end
    total++; if (MissedCnt !== 16'd1) begin bad++; $display("FAIL missed_cnt got=%0d exp=1", MissedCnt); end
    total++; if (Busy !== 4'h0) begin bad++; $display("FAIL missed_busy_end got=%b exp=0", Busy); end
    for (int j = 0; j < 4; j++) begin
      TriggerIn = (j < 2) ? 4'b0001 : 4'b0000;
      @(negedge Clk);
      if (j >= 1) begin
        total++;
        if (RAZ_CHN[0] !== (j >= 2)) begin bad++; $display("FAIL retrig_raz j=%0d got=%b exp=%b", j, RAZ_CHN[0], (j >= 2)); end
      end
    end
    repeat (40) @(negedge Clk);
  endtask

  task automatic test_force();
    logic [3:0] er;
    DelayTime = 6'd6; PulseWidth = 8'd3; HoldOff = 8'd0;
    for (int j = 0; j < 14; j++) begin
      TriggerIn = (j < 2) ? 4'b0001 : 4'b0000;
      ForceRaz  = (j >= 2 && j <= 6);
      @(negedge Clk);
      er = (j >= 2 && j <= 6) ? 4'b1111 : ((j >= 8 && j <= 10) ? 4'b0001 : 4'b0000);
      total++; if (RAZ_CHN !== er) begin bad++; $display("FAIL force_raz j=%0d got=%b exp=%b", j, RAZ_CHN, er); end
    end
    ForceRaz = 1'b0;
  endtask

  task automatic test_saturate_clear_reset();
    int n = 0;
    DelayTime = 6'd63; PulseWidth = 8'd255; HoldOff = 8'd255;
    ClearMissed = 1'b1; @(negedge Clk); ClearMissed = 1'b0;
    while (MissedCnt !== 16'hFFFF && n < 80000) begin
      TriggerIn = n[0] ? 4'b0101 : 4'b1010;
      @(negedge Clk);
      n++;
    end
    total++; if (MissedCnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", MissedCnt); end
    for (int j = 0; j < 4; j++) begin
      TriggerIn = ~TriggerIn;
      @(negedge Clk);
    end
    total++; if (MissedCnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", MissedCnt); end
    ClearMissed = 1'b1; TriggerIn = ~TriggerIn;
    @(negedge Clk);
    total++; if (MissedCnt !== 16'h0) begin bad++; $display("FAIL clear_prio got=%h exp=0", MissedCnt); end
    ClearMissed = 1'b0; TriggerIn = 4'b0000;
    repeat (4) @(negedge Clk);
    n = 0;
    while (Busy !== 4'h0 && n < 1500) begin @(negedge Clk); n++; end
    total++; if (Busy !== 4'h0) begin bad++; $display("FAIL idle_wait got=%b exp=0", Busy); end
    DelayTime = 6'd0; PulseWidth = 8'd10; HoldOff = 8'd0;
    for (int j = 0; j < 6; j++) begin
      TriggerIn = (j < 2) ? 4'b0001 : 4'b0000;
      @(negedge Clk);
    end
    total++; if (RAZ_CHN !== 4'b0001) begin bad++; $display("FAIL mid_pulse_raz got=%b exp=0001", RAZ_CHN); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (RAZ_CHN !== 4'h0) begin bad++; $display("FAIL async_rst_raz got=%b exp=0", RAZ_CHN); end
    total++; if (Busy !== 4'h0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", Busy); end
    total++; if (MissedCnt !== 16'h0) begin bad++; $display("FAIL async_rst_missed got=%h exp=0", MissedCnt); end
    @(negedge Clk); reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; TriggerIn = '0; RazEn = 4'b1111; GlobalMode = 1'b0;
    DelayTime = '0; PulseWidth = '0; HoldOff = '0; ForceRaz = 1'b0; ClearMissed = 1'b0;
    test_reset();
    test_basic();
    test_zero_delay_width();
    test_global();
    test_missed();
    test_force();
    test_saturate_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
